// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix result read window.
package matrix_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int STAT_FULL_BIT = 0;
  localparam int STAT_OVR_BIT  = 1;

  function automatic int word_bytes(input int bits, input int width);
    return (width * bits) / 8;
  endfunction

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] len);
    return (addr >= base) && (addr < base + len);
  endfunction

endpackage

// File: rtl/out_matrix_word_mux.sv
// Word select from the snapshot buffer; column-major (transposed) order when
// OUT_MATRIX_TRANSPOSE_EN is defined, row-major otherwise.
module out_matrix_word_mux #(
  parameter int BITS  = 8,
  parameter int N     = 8,
  parameter int WIDTH = 4,
  parameter int IDX_W = 4
) (
  input  logic [N*N*BITS-1:0]   mat_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [WIDTH*BITS-1:0] word_o
);

  localparam int WORD_W = WIDTH * BITS;
  localparam int WORDS  = (N * N) / WIDTH;

  always_comb begin
    word_o = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_i == IDX_W'(w)) begin
`ifdef OUT_MATRIX_TRANSPOSE_EN
        // Linear position p = w*WIDTH+j maps to row p%N, col p/N of C.
        for (int j = 0; j < WIDTH; j++) begin
          word_o[j*BITS +: BITS] =
            mat_i[((((w*WIDTH + j) % N) * N) + ((w*WIDTH + j) / N))*BITS +: BITS];
        end
`else
        word_o = mat_i[w*WORD_W +: WORD_W];
`endif
      end
    end
  end

endmodule

// File: rtl/out_matrix_reader.sv
// Snapshots the multiplier result and serves it as bus words with read tracking,
// drain/overrun status. Define OUT_MATRIX_TRANSPOSE_EN to serve C^T.
module out_matrix_reader
  import matrix_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int N          = 8,
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int OFFSET     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*N*BITS-1:0]    in_all,
  input  logic                   load,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic                   rd_en,
  output logic [WIDTH*BITS-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   drained
);

  localparam int WORD_W     = WIDTH * BITS;
  localparam int WORD_BYTES = word_bytes(BITS, WIDTH);
  localparam int WORDS      = (N * N) / WIDTH;
  localparam int MAT_BYTES  = (N * N * BITS) / 8;
  localparam int STAT_ADDR  = OFFSET + MAT_BYTES;
  localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e              state_q, state_d;
  logic [N*N*BITS-1:0] buf_q, buf_d;
  logic [WORDS-1:0]    mask_q, mask_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                drained_q, drained_d;
  logic                overrun_q, overrun_d;

  logic [31:0]         addr32;
  logic                mat_hit, stat_hit;
  logic [IDX_W-1:0]    idx;
  logic [WORD_W-1:0]   mat_word, stat_word;
  logic [WORDS-1:0]    mask_set;

  assign addr32   = 32'(addr);
  assign mat_hit  = rd_en && in_window(addr32, 32'(OFFSET), 32'(MAT_BYTES));
  assign stat_hit = rd_en && (addr32 == 32'(STAT_ADDR));
  assign idx      = IDX_W'((addr32 - 32'(OFFSET)) / 32'(WORD_BYTES));
  assign mask_set = mask_q | (WORDS'(1) << idx);

  out_matrix_word_mux #(
    .BITS  (BITS),
    .N     (N),
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_word_mux (
    .mat_i  (buf_q),
    .idx_i  (idx),
    .word_o (mat_word)
  );

  always_comb begin
    stat_word                = '0;
    stat_word[STAT_FULL_BIT] = (state_q == FULL);
    stat_word[STAT_OVR_BIT]  = overrun_q;
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    mask_d     = mask_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    drained_d  = 1'b0;
    overrun_d  = overrun_q;

    if (mat_hit) begin
      rd_data_d  = mat_word;
      rd_valid_d = 1'b1;
    end else if (stat_hit) begin
      rd_data_d  = stat_word;
      rd_valid_d = 1'b1;
      overrun_d  = 1'b0;
    end

    // A load always wins: it discards any same-cycle mask update and drain.
    if (load) begin
      buf_d   = in_all;
      mask_d  = '0;
      state_d = FULL;
      if (state_q == FULL) overrun_d = 1'b1;
    end else if (mat_hit && state_q == FULL) begin
      if (&mask_set) begin
        mask_d    = '0;
        state_d   = EMPTY;
        drained_d = 1'b1;
      end else begin
        mask_d = mask_set;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      buf_q      <= '0;
      mask_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      drained_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      mask_q     <= mask_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      drained_q  <= drained_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign full     = (state_q == FULL);
  assign drained  = drained_q;

endmodule
